// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM split into byte lanes, fixed-latency
// valid/ready request with a one-cycle response strobe.

module dmem_lane #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [7:0]            wbyte,
  output logic [7:0]            rbyte
);
  logic [7:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wbyte;

  assign rbyte = mem[idx];
endmodule

module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int NUM_LANES = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]              state;
  logic [3:0]              cnt;
  logic                    cap_we, cap_uns;
  logic [1:0]              cap_size;
  logic [ADDR_WIDTH+1:0]   cap_addr;
  logic [31:0]             cap_wdata;

  logic                    go_resp;
  logic                    s_we, s_uns, s_err;
  logic [1:0]              s_size, s_lane;
  logic [ADDR_WIDTH+1:0]   s_addr;
  logic [ADDR_WIDTH-1:0]   s_idx;
  logic [31:0]             s_wdata, rword, ld;
  logic [NUM_LANES-1:0]    be;
  logic [NUM_LANES-1:0][7:0] lane_wdata, lane_rdata;
  logic [7:0]              bsel;
  logic [15:0]             hsel;
  logic                    unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
  assign req_ready   = (state == IDLE);

  // With no wait states the access happens on the accept edge itself,
  // so the live request feeds the RAM instead of the capture registers.
  assign go_resp = (NO_WAIT && state == IDLE && req_valid) ||
                   (state == WAIT && cnt == 4'd0);
  assign s_we    = (state == IDLE) ? req_we       : cap_we;
  assign s_uns   = (state == IDLE) ? req_unsigned : cap_uns;
  assign s_size  = (state == IDLE) ? req_size     : cap_size;
  assign s_addr  = (state == IDLE) ? req_addr[ADDR_WIDTH+1:0] : cap_addr;
  assign s_wdata = (state == IDLE) ? req_wdata    : cap_wdata;
  assign s_lane  = s_addr[1:0];
  assign s_idx   = s_addr[ADDR_WIDTH+1:2];
  assign s_err   = (s_size == 2'b11) ||
                   (s_size == 2'b01 && s_addr[0]) ||
                   (s_size == 2'b10 && s_lane != 2'b00);

  always_comb begin
    be         = '0;
    lane_wdata = s_wdata;
    case (s_size)
      2'b00: begin
        be[s_lane] = 1'b1;
        lane_wdata = {NUM_LANES{s_wdata[7:0]}};
      end
      2'b01: begin
        be         = s_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{s_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = '0;
    endcase
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      dmem_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
        .clk   (clk),
        .we    (go_resp & s_we & ~s_err & be[g]),
        .idx   (s_idx),
        .wbyte (lane_wdata[g]),
        .rbyte (lane_rdata[g])
      );
    end
  endgenerate

  assign rword = lane_rdata;

  always_comb begin
    bsel = lane_rdata[s_lane];
    hsel = s_addr[1] ? rword[31:16] : rword[15:0];
    case (s_size)
      2'b00:   ld = s_uns ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
      2'b01:   ld = s_uns ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
      default: ld = rword;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_uns   <= 1'b0;
      cap_size  <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cap_we    <= req_we;
          cap_uns   <= req_unsigned;
          cap_size  <= req_size;
          cap_addr  <= req_addr[ADDR_WIDTH+1:0];
          cap_wdata <= req_wdata;
          cnt       <= CNT_INIT;
          state     <= NO_WAIT ? RESP : WAIT;
        end
        WAIT: if (cnt == 4'd0) state <= RESP;
              else             cnt   <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= go_resp;
      resp_err   <= go_resp & s_err;
      resp_rdata <= (go_resp && !s_we && !s_err) ? ld : 32'd0;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder, plus a short directed
// latency run on a zero-wait-state instance.

module tb_dmem_responder;
  localparam int AW = 10;
  localparam int W  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we, z_req_unsigned;
  logic [1:0]  z_req_size;
  logic [31:0] z_req_addr, z_req_wdata;
  logic        z_resp_valid, z_resp_err;
  logic [31:0] z_resp_rdata;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err));

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_size(z_req_size), .req_unsigned(z_req_unsigned),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .resp_valid(z_resp_valid),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err));

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          due;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] ref_mem [4096];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: byte-addressed memory image; aliasing folds to the low 4 KiB.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic err);
    int base, n;
    base = int'(addr & 32'hFFF);
    err  = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
           (size == 2'd2 && addr[1:0] != 2'd0);
    rd   = 32'd0;
    if (err) return;
    n = 1 << size;
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(wdata >> (8 * i));
    end else begin
      for (int i = 0; i < n; i++) rd = rd | (32'(ref_mem[base + i]) << (8 * i));
      if (n < 4 && !uns && rd[8 * n - 1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
    end
  endfunction

  task automatic garbage();
    req_valid    = 1'($urandom);
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit track = 1'b1);
    int tries = 0;
    int acc;
    logic [31:0] rd;
    logic err;
    @(negedge clk);
    while (!req_ready && tries < 50) begin
      garbage();
      tries++;
      @(negedge clk);
    end
    if (!req_ready) begin
      chk("req_ready_timeout", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    acc = cyc;
    @(posedge clk);
    if (track) begin
      model(we, size, uns, addr, wdata, rd, err);
      sbq.push_back('{rd, err, acc + 1 + W});
    end
    #1;
    garbage();
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp", {31'b0, resp_valid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("rdata", resp_rdata, e.rd);
        chk("err", {31'b0, resp_err}, {31'b0, e.err});
        chk("latency", cyc, e.due);
      end
    end else begin
      chk("idle_rdata", resp_rdata, 32'd0);
    end
  end

  task automatic z_issue(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err);
    int tries = 0;
    @(negedge clk);
    while (!z_req_ready && tries < 20) begin tries++; @(negedge clk); end
    chk({name, "_ready"}, {31'b0, z_req_ready}, 32'd1);
    z_req_valid = 1'b1; z_req_we = we; z_req_size = size; z_req_unsigned = uns;
    z_req_addr = addr; z_req_wdata = wdata;
    @(posedge clk);
    #1 z_req_valid = 1'b0;
    z_req_addr = $urandom; z_req_wdata = $urandom;
    @(negedge clk);
    chk({name, "_valid_t1"}, {31'b0, z_resp_valid}, 32'd1);
    chk({name, "_rdata"}, z_resp_rdata, exp_rd);
    chk({name, "_err"}, {31'b0, z_resp_err}, {31'b0, exp_err});
    @(negedge clk);
    chk({name, "_single"}, {31'b0, z_resp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          tries;
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_size = 2'd0; z_req_unsigned = 1'b0;
    z_req_addr = '0; z_req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_valid", {31'b0, resp_valid}, 32'd0);

    // Zero-wait instance: response one cycle after accept.
    z_issue("z_sw", 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D, 32'd0, 1'b0);
    z_issue("z_lw", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0);
    z_issue("z_lh", 1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 32'hFFFF_CAFE, 1'b0);
    z_issue("z_lbu", 1'b0, 2'd0, 1'b1, 32'h41, 32'h0, 32'h0000_00F0, 1'b0);

    // Give the exercised region known contents.
    for (int w = 0; w < 64; w++) issue(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00A5);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_8001);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFF_FFFF);
    issue(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFF_FFFF);
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

    for (int k = 0; k < 300; k++) begin
      sz = 2'($urandom);
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      issue(1'($urandom), sz, 1'($urandom), a, $urandom);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Reset while the store is still waiting: it must vanish without a trace.
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_valid", {31'b0, resp_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_no_resp", {31'b0, resp_valid}, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

    tries = 0;
    while (sbq.size() != 0 && tries < 20) begin tries++; @(negedge clk); end
    chk("drain", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
